seg7_scan_driver: RTL

Parametrised multiplexed 7-segment display driver. It holds an N-digit value (4 bits per digit), decodes each digit in BCD or hex mode, and time-multiplexes the digits onto one shared active-low segment bus with active-low anode enables. It sits between the datapath that produces the displayed number and the board's common-anode display pins. Loads are tear-free: a double buffer commits new values only at frame boundaries.

---
 rtl/seg7_pkg.sv | 48 ++++
 rtl/seg7_decode.sv | 12 +
 rtl/seg7_scan_driver.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared segment patterns and the digit-code decode function for the 7-segment scan driver.
// Patterns are {g,f,e,d,c,b,a} and active low.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_A    = 7'h08;
    localparam logic [6:0] SEG_B    = 7'h03;
    localparam logic [6:0] SEG_C    = 7'h46;
    localparam logic [6:0] SEG_D    = 7'h21;
    localparam logic [6:0] SEG_E    = 7'h06;
    localparam logic [6:0] SEG_F    = 7'h0E;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Codes 10..15 fall back to a dash outside hex mode so BCD displays never show letters.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] code, input logic hex_mode);
        logic [6:0] hex_pat;
        case (code)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    hex_pat = SEG_A;
            4'hB:    hex_pat = SEG_B;
            4'hC:    hex_pat = SEG_C;
            4'hD:    hex_pat = SEG_D;
            4'hE:    hex_pat = SEG_E;
            default: hex_pat = SEG_F;
        endcase
        return hex_mode ? hex_pat : SEG_DASH;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of one 4-bit digit code to an active-low segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    output logic [6:0] seg_n
);

    assign seg_n = digit_to_seg(code, hex_mode);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver: prescaler, digit scan, frame-aligned double buffer,
// leading-zero suppression and a registered output stage feeding the display pins.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int GUARD      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    hex_mode,
    input  logic                    lzs_en,
    input  logic                    blank,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]                 presc;
    logic [DW-1:0]                 dig;
    logic                          tick;
    logic                          boundary;
    logic [NUM_DIGITS-1:0][3:0]    act_val;
    logic [NUM_DIGITS-1:0][3:0]    pend_val;
    logic [NUM_DIGITS-1:0]         act_dp;
    logic [NUM_DIGITS-1:0]         pend_dp;
    logic                          pend_v;
    logic [NUM_DIGITS-1:0]         sup;
    logic                          in_guard;
    logic [6:0]                    dec_seg;
    logic [NUM_DIGITS-1:0]         an_d;

    assign tick     = (presc == PW'(DIV - 1));
    assign boundary = tick && (dig == DW'(NUM_DIGITS - 1));

    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (presc < PW'(GUARD));
        end
    endgenerate

    // Prescaler and digit scan counter; the digit wrap marks the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            dig   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) dig <= (dig == DW'(NUM_DIGITS - 1)) ? '0 : dig + 1'b1;
        end
    end

    // Double buffer: loads land in pending; active only changes at a frame boundary so a
    // frame never mixes old and new digits. A coincident load re-arms pend_v for next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_val  <= '0;
            act_dp   <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend_v   <= 1'b0;
        end else begin
            if (boundary && pend_v) begin
                act_val <= pend_val;
                act_dp  <= pend_dp;
                pend_v  <= 1'b0;
            end
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend_v   <= 1'b1;
            end
        end
    end

    // Leading-zero suppression: walk from the most significant digit down while all are zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        sup      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_val[i] == 4'h0);
            if (i > 0) sup[i] = lzs_en && zero_run;
        end
    end

    seg7_decode u_dec (
        .code     (act_val[dig]),
        .hex_mode (hex_mode),
        .seg_n    (dec_seg)
    );

    // Anode select: all off while blanked or in the ghost-suppression guard window.
    always_comb begin
        an_d = '1;
        if (!(blank || in_guard)) an_d[dig] = 1'b0;
    end

    // Output register so every pin comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= sup[dig] ? SEG_OFF : dec_seg;
            dp_n       <= ~act_dp[dig];
            an_n       <= an_d;
            frame_done <= boundary;
        end
    end

endmodule
